// File: rtl/memory_sequencer.sv
// memory_sequencer: shares the single memory op port between branch, data
// and fetch requesters, expanding each request into its memory op sequence.
// Optional build macro: MEMSEQ_ROUND_ROBIN_EN (alternate data/fetch service).
package memory_sequencer_pkg;
  typedef enum logic [2:0] {
    MEM_NOP      = 3'd0,
    MEM_READ     = 3'd1,
    MEM_WRITE    = 3'd2,
    MEM_INC      = 3'd3,
    MEM_ABSOLUTE = 3'd4,
    MEM_REL_ADD  = 3'd5,
    MEM_REL_SUB  = 3'd6
  } memory_op_e;

  typedef enum logic {
    BUS_MAR = 1'b0,
    BUS_PC  = 1'b1
  } memory_bus_selector_e;
endpackage

module memory_sequencer
  import memory_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_req,
  output logic                 fetch_ack,
  output logic [15:0]          fetch_instr,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [7:0]           data_addr,
  input  logic                 data_sel,
  input  logic [7:0]           data_wdata,
  output logic                 data_ack,
  output logic [7:0]           data_rdata,
  input  logic                 branch_req,
  input  logic [1:0]           branch_mode,
  input  logic [7:0]           branch_value,
  output logic                 branch_ack,
  output memory_op_e           mem_op,
  output memory_bus_selector_e mem_bus_selector,
  output logic                 mem_word_selector,
  output logic [7:0]           mem_in,
  input  logic [7:0]           mem_out,
  output logic                 busy
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_BR     = 4'd1,
    ST_ACK_BR = 4'd2,
    ST_F_RD0  = 4'd3,
    ST_F_RD1  = 4'd4,
    ST_F_INC  = 4'd5,
    ST_ACK_F  = 4'd6,
    ST_D_SET  = 4'd7,
    ST_D_WR   = 4'd8,
    ST_D_RD   = 4'd9,
    ST_D_CAP  = 4'd10,
    ST_ACK_D  = 4'd11
  } state_e;

  state_e               state_r;
  memory_op_e           mem_op_r;
  memory_bus_selector_e bus_r;
  logic                 word_sel_r;
  logic [7:0]           mem_in_r;
  logic                 fetch_ack_r;
  logic                 data_ack_r;
  logic                 branch_ack_r;
  logic [15:0]          fetch_instr_r;
  logic [7:0]           data_rdata_r;
  logic [7:0]           instr_hi_r;
  logic                 we_r;
  logic                 sel_r;
  logic [7:0]           wdata_r;
  logic                 busy_r;
  logic                 grant_data_s;

  // Reserved branch mode falls back to an absolute PC load
  function automatic memory_op_e branch_op(input logic [1:0] mode);
    case (mode)
      2'd1:    branch_op = MEM_REL_ADD;
      2'd2:    branch_op = MEM_REL_SUB;
      default: branch_op = MEM_ABSOLUTE;
    endcase
  endfunction

`ifdef MEMSEQ_ROUND_ROBIN_EN
  logic last_fetch_r;

  // Track which of data/fetch was granted most recently
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_fetch_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && !branch_req && (data_req || fetch_req)) begin
      last_fetch_r <= !grant_data_s;
    end else begin
      last_fetch_r <= last_fetch_r;
    end
  end
`endif

  // Decide whether data wins over fetch when both are pending
  always_comb begin
    grant_data_s = 1'b0;
    if (data_req && fetch_req) begin
`ifdef MEMSEQ_ROUND_ROBIN_EN
      grant_data_s = last_fetch_r;
`else
      grant_data_s = 1'b1;
`endif
    end else begin
      grant_data_s = data_req;
    end
  end

  // Sequencer FSM; memory outputs are registered for the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      mem_op_r      <= MEM_NOP;
      bus_r         <= BUS_MAR;
      word_sel_r    <= 1'b0;
      mem_in_r      <= 8'd0;
      fetch_ack_r   <= 1'b0;
      data_ack_r    <= 1'b0;
      branch_ack_r  <= 1'b0;
      fetch_instr_r <= 16'd0;
      data_rdata_r  <= 8'd0;
      instr_hi_r    <= 8'd0;
      we_r          <= 1'b0;
      sel_r         <= 1'b0;
      wdata_r       <= 8'd0;
      busy_r        <= 1'b0;
    end else begin
      mem_op_r     <= MEM_NOP;
      bus_r        <= BUS_MAR;
      word_sel_r   <= 1'b0;
      mem_in_r     <= 8'd0;
      fetch_ack_r  <= 1'b0;
      data_ack_r   <= 1'b0;
      branch_ack_r <= 1'b0;
      busy_r       <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (branch_req) begin
            state_r  <= ST_BR;
            mem_op_r <= branch_op(branch_mode);
            bus_r    <= BUS_PC;
            mem_in_r <= branch_value;
          end else if (grant_data_s) begin
            state_r  <= ST_D_SET;
            mem_op_r <= MEM_ABSOLUTE;
            mem_in_r <= data_addr;
            we_r     <= data_we;
            sel_r    <= data_sel;
            wdata_r  <= data_wdata;
          end else if (fetch_req) begin
            state_r  <= ST_F_RD0;
            mem_op_r <= MEM_READ;
            bus_r    <= BUS_PC;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_BR: begin
          state_r      <= ST_ACK_BR;
          branch_ack_r <= 1'b1;
        end
        ST_F_RD0: begin
          state_r    <= ST_F_RD1;
          mem_op_r   <= MEM_READ;
          bus_r      <= BUS_PC;
          word_sel_r <= 1'b1;
        end
        ST_F_RD1: begin
          state_r    <= ST_F_INC;
          instr_hi_r <= mem_out;
          mem_op_r   <= MEM_INC;
          bus_r      <= BUS_PC;
        end
        ST_F_INC: begin
          state_r       <= ST_ACK_F;
          fetch_instr_r <= {instr_hi_r, mem_out};
          fetch_ack_r   <= 1'b1;
        end
        ST_D_SET: begin
          word_sel_r <= sel_r;
          if (we_r) begin
            state_r  <= ST_D_WR;
            mem_op_r <= MEM_WRITE;
            mem_in_r <= wdata_r;
          end else begin
            state_r  <= ST_D_RD;
            mem_op_r <= MEM_READ;
          end
        end
        ST_D_WR: begin
          state_r    <= ST_ACK_D;
          data_ack_r <= 1'b1;
        end
        ST_D_RD: begin
          state_r <= ST_D_CAP;
        end
        ST_D_CAP: begin
          state_r      <= ST_ACK_D;
          data_rdata_r <= mem_out;
          data_ack_r   <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_op            = mem_op_r;
  assign mem_bus_selector  = bus_r;
  assign mem_word_selector = word_sel_r;
  assign mem_in            = mem_in_r;
  assign fetch_ack         = fetch_ack_r;
  assign fetch_instr       = fetch_instr_r;
  assign data_ack          = data_ack_r;
  assign data_rdata        = data_rdata_r;
  assign branch_ack        = branch_ack_r;
  assign busy              = busy_r;

endmodule

// File: tb/tb_memory_sequencer.sv
// Bench for memory_sequencer: behavioural memory block plus a transaction-level
// reference (PC and cell contents) checked against DUT results and latencies.
module tb_memory_sequencer;
  import memory_sequencer_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 fetch_req;
  logic                 fetch_ack;
  logic [15:0]          fetch_instr;
  logic                 data_req;
  logic                 data_we;
  logic [7:0]           data_addr;
  logic                 data_sel;
  logic [7:0]           data_wdata;
  logic                 data_ack;
  logic [7:0]           data_rdata;
  logic                 branch_req;
  logic [1:0]           branch_mode;
  logic [7:0]           branch_value;
  logic                 branch_ack;
  memory_op_e           mem_op;
  memory_bus_selector_e mem_bus_selector;
  logic                 mem_word_selector;
  logic [7:0]           mem_in;
  logic [7:0]           mem_out;
  logic                 busy;

  memory_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .fetch_req         (fetch_req),
    .fetch_ack         (fetch_ack),
    .fetch_instr       (fetch_instr),
    .data_req          (data_req),
    .data_we           (data_we),
    .data_addr         (data_addr),
    .data_sel          (data_sel),
    .data_wdata        (data_wdata),
    .data_ack          (data_ack),
    .data_rdata        (data_rdata),
    .branch_req        (branch_req),
    .branch_mode       (branch_mode),
    .branch_value      (branch_value),
    .branch_ack        (branch_ack),
    .mem_op            (mem_op),
    .mem_bus_selector  (mem_bus_selector),
    .mem_word_selector (mem_word_selector),
    .mem_in            (mem_in),
    .mem_out           (mem_out),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory block
  logic [7:0] m_c0 [256];
  logic [7:0] m_c1 [256];
  logic [7:0] m_pc;
  logic [7:0] m_mar;
  logic [7:0] m_addr;
  logic       mem_init;

  function automatic logic [7:0] init_c0(input int i);
    return 8'(32'h12 + i * 3);
  endfunction

  function automatic logic [7:0] init_c1(input int i);
    return 8'(32'h34 ^ i);
  endfunction

  assign m_addr = (mem_bus_selector == BUS_PC) ? m_pc : m_mar;

  // Apply the driven memory op on each rising edge
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        m_c0[i] <= init_c0(i);
        m_c1[i] <= init_c1(i);
      end
      m_pc    <= 8'd0;
      m_mar   <= 8'd0;
      mem_out <= 8'd0;
    end else begin
      case (mem_op)
        MEM_READ:  mem_out <= mem_word_selector ? m_c1[m_addr] : m_c0[m_addr];
        MEM_WRITE: begin
          if (mem_word_selector) m_c1[m_addr] <= mem_in;
          else m_c0[m_addr] <= mem_in;
        end
        MEM_INC: begin
          if (mem_bus_selector == BUS_PC) m_pc <= m_pc + 8'd1;
          else m_mar <= m_mar + 8'd1;
        end
        MEM_ABSOLUTE: begin
          if (mem_bus_selector == BUS_PC) m_pc <= mem_in;
          else m_mar <= mem_in;
        end
        MEM_REL_ADD: begin
          if (mem_bus_selector == BUS_PC) m_pc <= m_pc + mem_in;
          else m_mar <= m_mar + mem_in;
        end
        MEM_REL_SUB: begin
          if (mem_bus_selector == BUS_PC) m_pc <= m_pc - mem_in;
          else m_mar <= m_mar - mem_in;
        end
        default: ;
      endcase
    end
  end

  // Transaction-level reference state
  logic [7:0] r_c0 [256];
  logic [7:0] r_c1 [256];
  logic [7:0] r_pc;

  int num_checks = 0;
  int num_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait for the chosen ack (0 branch, 1 data, 2 fetch); lat = cycles from grant
  task automatic wait_ack(input int which, output int lat);
    logic seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clock);
      lat++;
      seen = (which == 0) ? branch_ack : ((which == 1) ? data_ack : fetch_ack);
      if (lat == 1) begin
        branch_value = 8'($urandom);
        branch_mode  = 2'($urandom);
        data_addr    = 8'($urandom);
        data_sel     = 1'($urandom);
        data_wdata   = 8'($urandom);
        data_we      = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          if (which == 0) branch_req = 1'b0;
          else if (which == 1) data_req = 1'b0;
          else fetch_req = 1'b0;
        end
      end
    end
    if (!seen) lat = 99;
  endtask

  task automatic do_branch(input logic [1:0] mode, input logic [7:0] val);
    int lat;
    branch_mode = mode; branch_value = val; branch_req = 1'b1;
    wait_ack(0, lat);
    branch_req = 1'b0;
    check_eq("br_lat", 32'(lat), 32'd2);
    case (mode)
      2'd1:    r_pc = r_pc + val;
      2'd2:    r_pc = r_pc - val;
      default: r_pc = val;
    endcase
    @(negedge clock);
  endtask

  task automatic do_store(input logic [7:0] a, input logic s, input logic [7:0] d);
    int lat;
    data_addr = a; data_sel = s; data_wdata = d; data_we = 1'b1; data_req = 1'b1;
    wait_ack(1, lat);
    data_req = 1'b0;
    check_eq("st_lat", 32'(lat), 32'd3);
    if (s) r_c1[a] = d;
    else r_c0[a] = d;
    @(negedge clock);
  endtask

  task automatic do_load(input logic [7:0] a, input logic s);
    int lat;
    logic [7:0] exp;
    exp = s ? r_c1[a] : r_c0[a];
    data_addr = a; data_sel = s; data_wdata = 8'($urandom); data_we = 1'b0; data_req = 1'b1;
    wait_ack(1, lat);
    data_req = 1'b0;
    check_eq("ld_lat", 32'(lat), 32'd4);
    check_eq("ld_data", 32'(data_rdata), 32'(exp));
    @(negedge clock);
  endtask

  task automatic do_fetch();
    int lat;
    logic [15:0] exp;
    exp = {r_c0[r_pc], r_c1[r_pc]};
    fetch_req = 1'b1;
    wait_ack(2, lat);
    fetch_req = 1'b0;
    check_eq("f_lat", 32'(lat), 32'd4);
    check_eq("f_instr", 32'(fetch_instr), 32'(exp));
    r_pc = r_pc + 8'd1;
    @(negedge clock);
    check_eq("f_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int br_at;
    int f_at;
    int n_fetch;
    int n_f_ack;
    logic [15:0] exp_i;
    bit order[$];

    fetch_req = 1'b0; data_req = 1'b0; branch_req = 1'b0;
    data_we = 1'b0; data_addr = 8'd0; data_sel = 1'b0; data_wdata = 8'd0;
    branch_mode = 2'd0; branch_value = 8'd0;
    mem_init = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      r_c0[i] = init_c0(i);
      r_c1[i] = init_c1(i);
    end
    r_pc = 8'd0;

    // Reset state
    #1 reset = 1'b0;
    #1;
    check_eq("rst_fetch_ack", 32'(fetch_ack), 32'd0);
    check_eq("rst_data_ack", 32'(data_ack), 32'd0);
    check_eq("rst_branch_ack", 32'(branch_ack), 32'd0);
    check_eq("rst_fetch_instr", 32'(fetch_instr), 32'd0);
    check_eq("rst_data_rdata", 32'(data_rdata), 32'd0);
    check_eq("rst_mem_op", 32'(mem_op), 32'(MEM_NOP));
    check_eq("rst_bus", 32'(mem_bus_selector), 32'd0);
    check_eq("rst_ws", 32'(mem_word_selector), 32'd0);
    check_eq("rst_mem_in", 32'(mem_in), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    mem_init = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Fetch at PC=0: READ ws0, READ ws1, INC, then ack with 0x1234
    fetch_req = 1'b1;
    @(negedge clock);
    check_eq("f1_op1", 32'(mem_op), 32'(MEM_READ));
    check_eq("f1_ws1", 32'(mem_word_selector), 32'd0);
    check_eq("f1_bus1", 32'(mem_bus_selector), 32'(BUS_PC));
    check_eq("f1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check_eq("f1_op2", 32'(mem_op), 32'(MEM_READ));
    check_eq("f1_ws2", 32'(mem_word_selector), 32'd1);
    @(negedge clock);
    check_eq("f1_op3", 32'(mem_op), 32'(MEM_INC));
    check_eq("f1_ack3", 32'(fetch_ack), 32'd0);
    @(negedge clock);
    check_eq("f1_op4", 32'(mem_op), 32'(MEM_NOP));
    check_eq("f1_ack4", 32'(fetch_ack), 32'd1);
    check_eq("f1_instr", 32'(fetch_instr), 32'h1234);
    fetch_req = 1'b0;
    r_pc = 8'd1;
    @(negedge clock);
    check_eq("f1_ack_pulse", 32'(fetch_ack), 32'd0);

    // Store 0xAB to addr 0x20 sel 1, then load it back
    data_addr = 8'h20; data_sel = 1'b1; data_wdata = 8'hAB; data_we = 1'b1; data_req = 1'b1;
    @(negedge clock);
    check_eq("st_op1", 32'(mem_op), 32'(MEM_ABSOLUTE));
    check_eq("st_in1", 32'(mem_in), 32'h20);
    check_eq("st_bus1", 32'(mem_bus_selector), 32'(BUS_MAR));
    @(negedge clock);
    check_eq("st_op2", 32'(mem_op), 32'(MEM_WRITE));
    check_eq("st_ws2", 32'(mem_word_selector), 32'd1);
    check_eq("st_in2", 32'(mem_in), 32'hAB);
    @(negedge clock);
    check_eq("st_ack3", 32'(data_ack), 32'd1);
    data_req = 1'b0;
    r_c1[8'h20] = 8'hAB;
    @(negedge clock);
    do_load(8'h20, 1'b1);
    check_eq("ld_ab", 32'(data_rdata), 32'hAB);
    do_fetch();

    // PC=5, branch REL_SUB 2 and fetch together: branch first, fetch from PC=3
    do_branch(2'd0, 8'd5);
    branch_mode = 2'd2; branch_value = 8'd2; branch_req = 1'b1; fetch_req = 1'b1;
    br_at = 0; f_at = 0;
    exp_i = {r_c0[8'd3], r_c1[8'd3]};
    for (int k = 1; k <= 20 && f_at == 0; k++) begin
      @(negedge clock);
      if (branch_ack) begin br_at = k; branch_req = 1'b0; end
      if (fetch_ack) begin f_at = k; fetch_req = 1'b0; end
    end
    branch_req = 1'b0; fetch_req = 1'b0;
    check_eq("bf_br_at", 32'(br_at), 32'd2);
    check_eq("bf_f_at", 32'(f_at), 32'd7);
    check_eq("bf_instr", 32'(fetch_instr), 32'(exp_i));
    r_pc = 8'd4;
    @(negedge clock);

    // Contending data and fetch, starting from a fresh arbitration state
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    data_addr = 8'h20; data_sel = 1'b1; data_we = 1'b0; data_req = 1'b1; fetch_req = 1'b1;
    n_fetch = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clock);
      if (data_ack) begin
        check_eq("arb_ld", 32'(data_rdata), 32'(r_c1[8'h20]));
        if (cyc < 40) order.push_back(1'b0);
        else data_req = 1'b0;
      end
      if (fetch_ack) begin
        check_eq("arb_instr", 32'(fetch_instr), 32'({r_c0[r_pc], r_c1[r_pc]}));
        r_pc = r_pc + 8'd1;
        if (cyc < 40) begin order.push_back(1'b1); n_fetch++; end
        else fetch_req = 1'b0;
      end
      if (cyc >= 40 && !data_req && !fetch_req && !busy) break;
    end
    check_eq("arb_drain", 32'({data_req, fetch_req, busy}), 32'd0);
    data_req = 1'b0; fetch_req = 1'b0;
    repeat (8) @(negedge clock);
    check_eq("arb_count_ok", 32'(order.size() >= 6), 32'd1);
`ifdef MEMSEQ_ROUND_ROBIN_EN
    for (int i = 0; i < order.size(); i++) check_eq("arb_rr_order", 32'(order[i]), 32'(i % 2));
`else
    check_eq("arb_fetch_starved", 32'(n_fetch), 32'd0);
    for (int i = 0; i < order.size(); i++) check_eq("arb_fixed_order", 32'(order[i]), 32'd0);
`endif

    // Reset during F_RD1 aborts the fetch
    fetch_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_eq("ra_op_rd1", 32'(mem_op), 32'(MEM_READ));
    check_eq("ra_ws_rd1", 32'(mem_word_selector), 32'd1);
    reset = 1'b0;
    fetch_req = 1'b0;
    #1;
    check_eq("ra_op", 32'(mem_op), 32'(MEM_NOP));
    check_eq("ra_busy", 32'(busy), 32'd0);
    check_eq("ra_instr", 32'(fetch_instr), 32'd0);
    check_eq("ra_ack", 32'(fetch_ack), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n_f_ack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (fetch_ack) n_f_ack++;
    end
    check_eq("ra_no_ack", 32'(n_f_ack), 32'd0);
    do_fetch();

    // Randomized mix of transactions
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        32'd0:   do_branch(2'($urandom), 8'($urandom));
        32'd1:   do_store(8'($urandom_range(0, 15)), 1'($urandom), 8'($urandom));
        32'd2:   do_load(8'($urandom_range(0, 15)), 1'($urandom));
        default: do_fetch();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/memory_sequencer.md
Name: memory_sequencer

Overview:
Controller in front of the memory block (MAR/PC address registers, 2-byte cells, op-driven). Shares the single memory op port between three requesters: branch (PC update), data (load/store through MAR) and fetch (16-bit instruction word at PC, then PC increment). Converts each request into the memory op sequence and returns results with a one-cycle ack pulse.

Parameters:
none; data path fixed at 8 bits, instruction word 16 bits.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_req  in  1  request a 16-bit instruction fetch at PC
fetch_ack  out  1  one-cycle pulse; fetch_instr valid in that cycle
fetch_instr  out  16  {byte at word_sel 0, byte at word_sel 1}; held until next fetch_ack
data_req  in  1  request a data access through MAR
data_we  in  1  1 = store, 0 = load; sampled at grant
data_addr  in  8  MAR value (zero-extended by memory)
data_sel  in  1  byte select within the addressed word
data_wdata  in  8  store data
data_ack  out  1  one-cycle completion pulse
data_rdata  out  8  load data; valid with data_ack, held afterwards
branch_req  in  1  request a PC update
branch_mode  in  2  0 ABSOLUTE, 1 REL_ADD, 2 REL_SUB, 3 reserved (treated as ABSOLUTE)
branch_value  in  8  absolute target or offset
branch_ack  out  1  one-cycle completion pulse
mem_op  out  memory_op_e  op driven to the memory block
mem_bus_selector  out  memory_bus_selector_e  0 MAR, 1 PC
mem_word_selector  out  1  data word selector
mem_in  out  8  memory input bus
mem_out  in  8  memory read data; valid the cycle after a READ op
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset==0): state IDLE, all acks 0, fetch_instr 0, data_rdata 0, mem_op NOP (default/no-op encoding), mem_bus_selector 0, mem_word_selector 0, mem_in 0. Takes effect immediately and aborts any transaction: no ack, no partial result.
- Memory outputs are a pure function of state and latched request fields; no combinational path from any *_req to mem_*.
- Request fields (we, addr, sel, wdata, mode, value) latched at grant in IDLE; later changes are ignored.
- Requests are level; a requester holds req until its ack. Dropping req after grant does not abort; the sequence completes and ack still pulses.
- FSM states and ops:
  IDLE: NOP; grant per priority below.
  BR: op by mode on PC bus, mem_in=value -> ACK_BR.
  F_RD0: READ, PC bus, word_sel 0 -> F_RD1.
  F_RD1: READ, PC bus, word_sel 1; capture mem_out into fetch_instr[15:8] -> F_INC.
  F_INC: INC, PC bus; capture mem_out into fetch_instr[7:0] -> ACK_F.
  D_SET: ABSOLUTE, MAR bus, mem_in=addr -> D_WR if we else D_RD.
  D_WR: WRITE, MAR bus, word_sel=sel, mem_in=wdata -> ACK_D.
  D_RD: READ, MAR bus, word_sel=sel -> D_CAP.
  D_CAP: NOP; capture mem_out into data_rdata -> ACK_D.
  ACK_x: NOP; pulse the matching ack for exactly one cycle -> IDLE.
- Latency grant-to-ack: branch 2, fetch 4, store 3, load 4 cycles. No back-to-back grants; IDLE is always visited for at least one cycle between transactions.
- Priority (default): branch > data > fetch. A pending branch is taken before a fetch so the fetched word comes from the updated PC.
- PC/MAR wrap-around is handled by the memory block; the sequencer performs no address arithmetic.

Optional Feature:
MEMSEQ_ROUND_ROBIN_EN: when defined, branch stays highest; between data and fetch a one-bit last-served flag (reset to "fetch") gives priority to the requester not served last, so continuous data and fetch requests alternate. When undefined, fixed branch > data > fetch applies and a continuous data_req starves fetch.

Test Plan:
- Reset, cells[0]={0x12,0x34}, PC=0, fetch_req=1 -> mem_op READ(ws0), READ(ws1), INC, NOP; fetch_ack at grant+4, fetch_instr=0x1234, PC=1.
- data_req store addr=0x20 sel=1 wdata=0xAB, then load same address -> ABSOLUTE(mem_in 0x20), WRITE(ws1, 0xAB), data_ack; load returns data_rdata=0xAB with data_ack at grant+4.
- PC=5, fetch_req and branch_req (REL_SUB, 2) in the same cycle -> branch served first (branch_ack), then fetch reads word at PC=3.
- data_req and fetch_req held high for 20 cycles -> without macro only data_acks; with MEMSEQ_ROUND_ROBIN_EN data_ack and fetch_ack alternate, first served is data.
- reset driven to 0 during F_RD1 -> mem_op NOP in the same cycle, no fetch_ack, fetch_instr=0, busy=0; after release next fetch_req completes normally.
